// File: rtl/seq_loop_pkg.sv
// seq_loop_pkg: loop tracker state type and saturating increment shared by the monitor
package seq_loop_pkg;
  typedef enum logic {IDLE, ACTIVE} loop_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    m = w >= 32 ? '1 : (32'd1 << w) - 32'd1;
    return v >= m ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/seq_loop_tracker.sv
// seq_loop_tracker: tracks entry, iterations, trip length, exit and stalls of one sequential loop
module seq_loop_tracker
  import seq_loop_pkg::*;
#(
  parameter int FSM_WIDTH   = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 hold,
  input  logic [FSM_WIDTH-1:0] cur_state,
  input  logic [FSM_WIDTH-1:0] prev_state,
  input  logic [FSM_WIDTH-1:0] start_state,
  input  logic [FSM_WIDTH-1:0] end_state,
  input  logic [FSM_WIDTH-1:0] quit_state,
  input  logic                 one_state,
  output logic                 active,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic [CNT_WIDTH-1:0] trip_cycles,
  output logic                 stall_err
);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  loop_state_t st;
  logic [SW-1:0] stall_cnt;
  logic at_start, exit_now, iter_hit, same;
  always_comb begin
    at_start = cur_state == start_state;
    exit_now = prev_state == quit_state && !at_start;
    iter_hit = at_start && (one_state || prev_state == end_state);
    same     = !one_state && cur_state == prev_state;
  end
  assign active = st == ACTIVE;
  always_ff @(posedge clock) begin
    if (!reset) begin
      st          <= IDLE;
      done        <= 1'b0;
      iter_count  <= '0;
      trip_cycles <= '0;
      stall_cnt   <= '0;
      stall_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!hold) begin
        if (st == IDLE) begin
          if (at_start) begin
            st          <= ACTIVE;
            iter_count  <= CNT_WIDTH'(1);
            trip_cycles <= CNT_WIDTH'(1);
            stall_cnt   <= '0;
          end
        end else if (exit_now) begin
          st        <= IDLE;
          done      <= 1'b1;
          stall_cnt <= '0;
        end else begin
          trip_cycles <= CNT_WIDTH'(sat_inc(32'(trip_cycles), CNT_WIDTH));
          if (iter_hit) iter_count <= CNT_WIDTH'(sat_inc(32'(iter_count), CNT_WIDTH));
          stall_cnt <= !same ? '0 : stall_cnt == SW'(STALL_LIMIT) ? stall_cnt : stall_cnt + SW'(1);
          if (same && stall_cnt >= SW'(STALL_LIMIT - 1)) stall_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/seq_loop_monitor.sv
// seq_loop_monitor: watches an FSM state and reports per-loop activity, iteration/cycle counts and stalls
module seq_loop_monitor
  import seq_loop_pkg::*;
#(
  parameter int FSM_WIDTH   = 2,
  parameter int NUM_LOOPS   = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [FSM_WIDTH-1:0]           cur_state,
  input  logic                           finish,
  input  logic [NUM_LOOPS*FSM_WIDTH-1:0] cfg_iter_start_state,
  input  logic [NUM_LOOPS*FSM_WIDTH-1:0] cfg_iter_end_state,
  input  logic [NUM_LOOPS*FSM_WIDTH-1:0] cfg_quit_state,
  input  logic [NUM_LOOPS-1:0]           cfg_one_state_loop,
  output logic [NUM_LOOPS-1:0]           loop_active,
  output logic [NUM_LOOPS-1:0]           loop_done,
  output logic [NUM_LOOPS*CNT_WIDTH-1:0] iter_count,
  output logic [NUM_LOOPS*CNT_WIDTH-1:0] trip_cycles,
  output logic [NUM_LOOPS-1:0]           stall_err,
  output logic                           frozen
);
  logic [FSM_WIDTH-1:0] prev_state;
  logic hold;
  always_comb hold = finish || frozen;
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_state <= '0;
      frozen     <= 1'b0;
    end else begin
      frozen <= hold;
      if (!hold) prev_state <= cur_state;
    end
  end
  for (genvar g = 0; g < NUM_LOOPS; g++) begin : g_loop
    seq_loop_tracker #(
      .FSM_WIDTH  (FSM_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .STALL_LIMIT(STALL_LIMIT)
    ) u_trk (
      .clock      (clock),
      .reset      (reset),
      .hold       (hold),
      .cur_state  (cur_state),
      .prev_state (prev_state),
      .start_state(cfg_iter_start_state[g*FSM_WIDTH +: FSM_WIDTH]),
      .end_state  (cfg_iter_end_state[g*FSM_WIDTH +: FSM_WIDTH]),
      .quit_state (cfg_quit_state[g*FSM_WIDTH +: FSM_WIDTH]),
      .one_state  (cfg_one_state_loop[g]),
      .active     (loop_active[g]),
      .done       (loop_done[g]),
      .iter_count (iter_count[g*CNT_WIDTH +: CNT_WIDTH]),
      .trip_cycles(trip_cycles[g*CNT_WIDTH +: CNT_WIDTH]),
      .stall_err  (stall_err[g])
    );
  end
endmodule

// File: tb/tb_seq_loop_monitor.sv
// tb_seq_loop_monitor: directed and randomized checks of seq_loop_monitor against a behavioural model
module tb_seq_loop_monitor;
  localparam int FW = 2;
  localparam int NL = 4;
  localparam int CW = 4;
  localparam int SL = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [FW-1:0] cur_state = '0;
  logic finish = 1'b0;
  logic [NL*FW-1:0] cfg_start, cfg_end, cfg_quit;
  logic [NL-1:0] cfg_one;
  logic [NL-1:0] loop_active, loop_done, stall_err;
  logic [NL*CW-1:0] iter_count, trip_cycles;
  logic frozen;
  int n_checks = 0;
  int n_fail = 0;
  bit m_act[NL], m_done[NL], m_err[NL];
  int m_iter[NL], m_trip[NL], m_run[NL];
  logic [FW-1:0] m_prev;
  bit m_frozen;

  seq_loop_monitor #(
    .FSM_WIDTH  (FW),
    .NUM_LOOPS  (NL),
    .CNT_WIDTH  (CW),
    .STALL_LIMIT(SL)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .cur_state           (cur_state),
    .finish              (finish),
    .cfg_iter_start_state(cfg_start),
    .cfg_iter_end_state  (cfg_end),
    .cfg_quit_state      (cfg_quit),
    .cfg_one_state_loop  (cfg_one),
    .loop_active         (loop_active),
    .loop_done           (loop_done),
    .iter_count          (iter_count),
    .trip_cycles         (trip_cycles),
    .stall_err           (stall_err),
    .frozen              (frozen)
  );

  always #5 clock = ~clock;

  task automatic set_cfg(input int i, input logic [FW-1:0] s, input logic [FW-1:0] e, input logic [FW-1:0] q, input logic o);
    cfg_start[i*FW +: FW] = s;
    cfg_end[i*FW +: FW] = e;
    cfg_quit[i*FW +: FW] = q;
    cfg_one[i] = o;
  endtask

  task automatic cfg_default;
    set_cfg(0, 2'd1, 2'd2, 2'd2, 1'b0);
    set_cfg(1, 2'd3, 2'd3, 2'd3, 1'b1);
    set_cfg(2, 2'd2, 2'd3, 2'd3, 1'b0);
    set_cfg(3, 2'd0, 2'd0, 2'd0, 1'b1);
  endtask

  task automatic model_edge(input logic [FW-1:0] s, input logic f, input logic r);
    if (!r) begin
      for (int i = 0; i < NL; i++) begin
        m_act[i] = 0; m_done[i] = 0; m_err[i] = 0;
        m_iter[i] = 0; m_trip[i] = 0; m_run[i] = 0;
      end
      m_prev = '0;
      m_frozen = 0;
    end else if (m_frozen || f) begin
      m_frozen = 1;
      for (int i = 0; i < NL; i++) m_done[i] = 0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        logic [FW-1:0] st, en, qu;
        bit one;
        st = cfg_start[i*FW +: FW];
        en = cfg_end[i*FW +: FW];
        qu = cfg_quit[i*FW +: FW];
        one = cfg_one[i];
        m_done[i] = 0;
        if (!m_act[i]) begin
          if (s == st) begin
            m_act[i] = 1; m_iter[i] = 1; m_trip[i] = 1; m_run[i] = 0;
          end
        end else if (m_prev == qu && s != st) begin
          m_act[i] = 0; m_done[i] = 1; m_run[i] = 0;
        end else begin
          m_trip[i] = m_trip[i] < MAXC ? m_trip[i] + 1 : MAXC;
          if (s == st && (one || m_prev == en)) m_iter[i] = m_iter[i] < MAXC ? m_iter[i] + 1 : MAXC;
          m_run[i] = (!one && s == m_prev) ? m_run[i] + 1 : 0;
          if (m_run[i] >= SL) m_err[i] = 1;
        end
      end
      m_prev = s;
    end
  endtask

  task automatic step(input logic [FW-1:0] s, input logic f, input logic r);
    cur_state = s;
    finish = f;
    reset = r;
    @(posedge clock);
    model_edge(s, f, r);
    #1;
  endtask

  task automatic do_reset;
    step(2'd0, 1'b0, 1'b0);
    step(2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    step(2'($urandom), 1'b1, 1'b0);
    step(2'($urandom), 1'b1, 1'b0);
    n_checks++; if (loop_active !== '0) begin n_fail++; $display("FAIL reset_active: got %b want 0", loop_active); end
    n_checks++; if (loop_done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0", loop_done); end
    n_checks++; if (iter_count !== '0) begin n_fail++; $display("FAIL reset_iter: got %h want 0", iter_count); end
    n_checks++; if (trip_cycles !== '0) begin n_fail++; $display("FAIL reset_trip: got %h want 0", trip_cycles); end
    n_checks++; if (stall_err !== '0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_err); end
    n_checks++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL reset_frozen: got %b want 0", frozen); end
  endtask

  task automatic test_multi_loop;
    logic [FW-1:0] seq [8];
    seq = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    do_reset;
    for (int k = 0; k < 8; k++) begin
      step(seq[k], 1'b0, 1'b1);
      n_checks++; if (loop_done[0] !== (k == 7)) begin n_fail++; $display("FAIL multi_done k=%0d: got %b want %b", k, loop_done[0], k == 7); end
      if (k == 1) begin
        n_checks++; if (loop_active[0] !== 1'b1 || iter_count[CW-1:0] !== 4'd1 || trip_cycles[CW-1:0] !== 4'd1) begin
          n_fail++; $display("FAIL multi_entry: got act=%b iter=%0d trip=%0d want 1/1/1", loop_active[0], iter_count[CW-1:0], trip_cycles[CW-1:0]);
        end
      end
    end
    n_checks++; if (iter_count[CW-1:0] !== 4'd3) begin n_fail++; $display("FAIL multi_iter: got %0d want 3", iter_count[CW-1:0]); end
    n_checks++; if (trip_cycles[CW-1:0] !== 4'd6) begin n_fail++; $display("FAIL multi_trip: got %0d want 6", trip_cycles[CW-1:0]); end
    n_checks++; if (loop_active[0] !== 1'b0) begin n_fail++; $display("FAIL multi_exit_active: got %b want 0", loop_active[0]); end
    step(2'd0, 1'b0, 1'b1);
    n_checks++; if (loop_done[0] !== 1'b0) begin n_fail++; $display("FAIL multi_pulse_width: got %b want 0", loop_done[0]); end
    n_checks++; if (iter_count[CW-1:0] !== 4'd3 || trip_cycles[CW-1:0] !== 4'd6) begin
      n_fail++; $display("FAIL multi_hold: got iter=%0d trip=%0d want 3/6", iter_count[CW-1:0], trip_cycles[CW-1:0]);
    end
  endtask

  task automatic test_one_state;
    do_reset;
    step(2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(2'd3, 1'b0, 1'b1);
    n_checks++; if (loop_active[1] !== 1'b1 || iter_count[CW +: CW] !== 4'd5 || trip_cycles[CW +: CW] !== 4'd5) begin
      n_fail++; $display("FAIL one_run: got act=%b iter=%0d trip=%0d want 1/5/5", loop_active[1], iter_count[CW +: CW], trip_cycles[CW +: CW]);
    end
    step(2'd0, 1'b0, 1'b1);
    n_checks++; if (loop_done[1] !== 1'b1 || loop_active[1] !== 1'b0) begin
      n_fail++; $display("FAIL one_exit: got done=%b act=%b want 1/0", loop_done[1], loop_active[1]);
    end
    n_checks++; if (iter_count[CW +: CW] !== 4'd5 || trip_cycles[CW +: CW] !== 4'd5) begin
      n_fail++; $display("FAIL one_hold: got iter=%0d trip=%0d want 5/5", iter_count[CW +: CW], trip_cycles[CW +: CW]);
    end
  endtask

  task automatic test_stall;
    do_reset;
    step(2'd0, 1'b0, 1'b1);
    step(2'd1, 1'b0, 1'b1);
    for (int k = 1; k <= SL; k++) begin
      step(2'd1, 1'b0, 1'b1);
      n_checks++; if (stall_err[0] !== (k == SL)) begin n_fail++; $display("FAIL stall_edge k=%0d: got %b want %b", k, stall_err[0], k == SL); end
    end
    step(2'd2, 1'b0, 1'b1);
    step(2'd3, 1'b0, 1'b1);
    n_checks++; if (loop_active[0] !== 1'b0 || loop_done[0] !== 1'b1) begin
      n_fail++; $display("FAIL stall_exit: got act=%b done=%b want 0/1", loop_active[0], loop_done[0]);
    end
    step(2'd0, 1'b0, 1'b1);
    n_checks++; if (stall_err[0] !== 1'b1) begin n_fail++; $display("FAIL stall_sticky: got %b want 1", stall_err[0]); end
  endtask

  task automatic test_saturation;
    do_reset;
    step(2'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step(2'd3, 1'b0, 1'b1);
      if (k == 14) begin
        n_checks++; if (iter_count[CW +: CW] !== 4'd14) begin n_fail++; $display("FAIL sat_pre: got %0d want 14", iter_count[CW +: CW]); end
      end
    end
    n_checks++; if (iter_count[CW +: CW] !== 4'd15) begin n_fail++; $display("FAIL sat_iter: got %0d want 15", iter_count[CW +: CW]); end
    n_checks++; if (trip_cycles[CW +: CW] !== 4'd15) begin n_fail++; $display("FAIL sat_trip: got %0d want 15", trip_cycles[CW +: CW]); end
    n_checks++; if (stall_err[1] !== 1'b0) begin n_fail++; $display("FAIL sat_no_stall: got %b want 0", stall_err[1]); end
  endtask

  task automatic test_finish_on_exit;
    do_reset;
    step(2'd0, 1'b0, 1'b1);
    step(2'd1, 1'b0, 1'b1);
    step(2'd2, 1'b0, 1'b1);
    step(2'd1, 1'b0, 1'b1);
    step(2'd2, 1'b0, 1'b1);
    step(2'd3, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (frozen !== 1'b1) begin n_fail++; $display("FAIL fin_frozen k=%0d: got %b want 1", k, frozen); end
      n_checks++; if (loop_active[0] !== 1'b1 || loop_done[0] !== 1'b0) begin
        n_fail++; $display("FAIL fin_state k=%0d: got act=%b done=%b want 1/0", k, loop_active[0], loop_done[0]);
      end
      n_checks++; if (iter_count[CW-1:0] !== 4'd2 || trip_cycles[CW-1:0] !== 4'd4) begin
        n_fail++; $display("FAIL fin_counts k=%0d: got iter=%0d trip=%0d want 2/4", k, iter_count[CW-1:0], trip_cycles[CW-1:0]);
      end
      step(k[0] ? 2'd3 : 2'd1, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_trip;
    do_reset;
    step(2'd0, 1'b0, 1'b1);
    step(2'd1, 1'b0, 1'b1);
    step(2'd2, 1'b0, 1'b1);
    step(2'd1, 1'b0, 1'b0);
    n_checks++; if (loop_active !== '0 || loop_done !== '0 || iter_count !== '0 || trip_cycles !== '0 || stall_err !== '0 || frozen !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear: got act=%b done=%b iter=%h trip=%h stall=%b frz=%b want all 0", loop_active, loop_done, iter_count, trip_cycles, stall_err, frozen);
    end
    step(2'd2, 1'b0, 1'b1);
    step(2'd3, 1'b0, 1'b1);
    n_checks++; if (loop_done !== '0) begin n_fail++; $display("FAIL midreset_no_done: got %b want 0", loop_done); end
  endtask

  task automatic test_random;
    logic [FW-1:0] s;
    logic f, r;
    logic [NL-1:0] e_act, e_done, e_err;
    logic [NL*CW-1:0] e_iter, e_trip;
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < NL; i++) set_cfg(i, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom));
      do_reset;
      s = '0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, round % 3 + 1) == 0) s = 2'($urandom);
        f = c > 300 && $urandom_range(0, 49) == 0;
        r = $urandom_range(0, 199) != 0;
        step(s, f, r);
        for (int i = 0; i < NL; i++) begin
          e_act[i] = m_act[i];
          e_done[i] = m_done[i];
          e_err[i] = m_err[i];
          e_iter[i*CW +: CW] = CW'(m_iter[i]);
          e_trip[i*CW +: CW] = CW'(m_trip[i]);
        end
        n_checks++; if (loop_active !== e_act) begin n_fail++; $display("FAIL rand_active r%0d c%0d: got %b want %b", round, c, loop_active, e_act); end
        n_checks++; if (loop_done !== e_done) begin n_fail++; $display("FAIL rand_done r%0d c%0d: got %b want %b", round, c, loop_done, e_done); end
        n_checks++; if (iter_count !== e_iter) begin n_fail++; $display("FAIL rand_iter r%0d c%0d: got %h want %h", round, c, iter_count, e_iter); end
        n_checks++; if (trip_cycles !== e_trip) begin n_fail++; $display("FAIL rand_trip r%0d c%0d: got %h want %h", round, c, trip_cycles, e_trip); end
        n_checks++; if (stall_err !== e_err) begin n_fail++; $display("FAIL rand_stall r%0d c%0d: got %b want %b", round, c, stall_err, e_err); end
        n_checks++; if (frozen !== m_frozen) begin n_fail++; $display("FAIL rand_frozen r%0d c%0d: got %b want %b", round, c, frozen, m_frozen); end
      end
    end
  endtask

  initial begin
    cfg_default;
    test_reset;
    test_multi_loop;
    test_one_state;
    test_stall;
    test_saturation;
    test_finish_on_exit;
    test_reset_mid_trip;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_loop_monitor.md
SEQ_LOOP_MONITOR -- requirements
Module: seq_loop_monitor

Interface
REQ-001 Parameter FSM_WIDTH, default 2: width of the monitored FSM state encoding.
REQ-002 Parameter NUM_LOOPS, default 4: number of independently tracked sequential loops.
REQ-003 Parameter CNT_WIDTH, default 16: width of every per-loop counter.
REQ-004 Parameter STALL_LIMIT, default 1024: consecutive unchanged-state cycles that flag a stall.
REQ-005 clock  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 cur_state  in  FSM_WIDTH  monitored design FSM state.
REQ-008 finish  in  1  end-of-simulation request; freezes the monitor.
REQ-009 cfg_iter_start_state  in  NUM_LOOPS*FSM_WIDTH  per-loop iteration start state; loop i in slice i.
REQ-010 cfg_iter_end_state  in  NUM_LOOPS*FSM_WIDTH  per-loop iteration end state.
REQ-011 cfg_quit_state  in  NUM_LOOPS*FSM_WIDTH  per-loop state from which the loop exits.
REQ-012 cfg_one_state_loop  in  NUM_LOOPS  loop i body is the single state iter_start_state.
REQ-013 loop_active  out  NUM_LOOPS  loop i currently executing.
REQ-014 loop_done  out  NUM_LOOPS  one-cycle pulse on loop i exit.
REQ-015 iter_count  out  NUM_LOOPS*CNT_WIDTH  iterations of current/last trip of loop i.
REQ-016 trip_cycles  out  NUM_LOOPS*CNT_WIDTH  cycles spent in current/last trip of loop i.
REQ-017 stall_err  out  NUM_LOOPS  sticky stall flag for loop i.
REQ-018 frozen  out  1  monitor frozen by finish.

Function
REQ-019 All outputs registered; the value of cur_state sampled at edge k is reflected on outputs after edge k.
REQ-020 A single prev_state register shall hold cur_state from the previous edge; reset value 0.
REQ-021 Per-loop FSM states IDLE and ACTIVE; IDLE->ACTIVE when cur_state==start: iter_count<=1, trip_cycles<=1.
REQ-022 In ACTIVE, trip_cycles shall increment by 1 per edge, saturating at 2^CNT_WIDTH-1.
REQ-023 In ACTIVE, multi-state loop: iter_count increments (saturating) when cur_state==start and prev_state==end.
REQ-024 In ACTIVE, one-state loop: iter_count increments (saturating) on every edge with cur_state==start after entry.
REQ-025 ACTIVE->IDLE when prev_state==quit and cur_state!=start; loop_done pulses 1 cycle; counters hold (exit edge not counted).
REQ-026 Re-entry from IDLE shall reload counters as in REQ-021; loop_done never asserts in the same cycle as re-entry.
REQ-027 Stall: in ACTIVE with cfg_one_state_loop=0, cur_state==prev_state for STALL_LIMIT consecutive edges sets stall_err; cleared only by reset.
REQ-028 Loops are independent; several may be ACTIVE simultaneously (nested loops).
REQ-029 finish=1 at an edge sets frozen; thereafter no FSM transition, counter change or new pulse until reset; finish beats a simultaneous exit or entry.
REQ-030 Configuration inputs are static after reset deassertion; changes mid-operation are undefined.

Reset
REQ-031 While reset==0 at an edge: loop_active=0, loop_done=0, iter_count=0, trip_cycles=0, stall_err=0, frozen=0, prev_state=0, stall counters=0.
REQ-032 Reset mid-trip shall abort tracking with no loop_done pulse.

Structure
REQ-033 Package seq_loop_pkg shall hold the loop FSM state enum and a saturating-increment function.
REQ-034 Sub-module seq_loop_tracker implements one loop (REQ-021..027) and is generated NUM_LOOPS times; top owns prev_state and frozen.

Verification
REQ-035 Loop0 start=1,end=2,quit=2; states 0,1,2,1,2,1,2,3 -> iter_count=3, trip_cycles=6, one loop_done pulse after the edge sampling 3.
REQ-036 Loop1 one-state, start=3, quit=3; state 3 for 5 edges then 0 -> iter_count=5, trip_cycles=5, loop_done pulse.
REQ-037 STALL_LIMIT=8, loop0 active, cur_state held at 1 for 8 edges -> stall_err[0]=1, stays 1 after loop exit.
REQ-038 CNT_WIDTH=4, one-state loop held 20 edges -> iter_count and trip_cycles saturate at 15.
REQ-039 finish asserted on loop0 exit edge -> frozen=1, loop_active[0] stays 1, no loop_done, counters frozen.
REQ-040 reset=0 for one edge mid-trip -> all outputs 0 next cycle, no loop_done pulse.
